bank_stream_ctrl: RTL

- Read sequencer for one port of a dual-port scratchpad bank in the GEMM accelerator; the other bank port stays with the CPU.
- Walks a 2-D tile (rows x cols, row stride) starting at a base address and issues one read per element.
- Absorbs the bank's 1-cycle read latency and streams the elements row-major to the systolic-array feeder over a valid/ready interface.

---
 rtl/bank_stream_ctrl_pkg.sv | 21 ++
 rtl/bank_stream_ctrl_if.sv | 40 ++++
 rtl/bank_stream_ctrl_skid_fifo.sv | 50 +++++
 rtl/bank_stream_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bank_stream_ctrl_pkg.sv
// Shared types for the bank read sequencer: FSM states, skid FIFO depth and
// the default element tag that travels with each read through the FIFO.
package bank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int TAG_D_WID  = 8;

    typedef struct packed {
        logic [TAG_D_WID-1:0] data;
        logic                 eol;
        logic                 last;
    } elem_tag_t;

endpackage

// File: rtl/bank_stream_ctrl_if.sv
// Bank read port plus element stream towards the systolic-array feeder.
// The sequencer takes the master side; the bank/feeder environment takes the slave side.
interface bank_stream_ctrl_if #(
    parameter int A_WID = 10,
    parameter int D_WID = 8
) ();

    logic             mem_en;
    logic [A_WID-1:0] mem_addr;
    logic [D_WID-1:0] mem_rdata;

    logic             out_valid;
    logic             out_ready;
    logic [D_WID-1:0] out_data;
    logic             out_eol;
    logic             out_last;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_eol,
        output out_last
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_eol,
        input  out_last
    );

endinterface

// File: rtl/bank_stream_ctrl_skid_fifo.sv
// Small skid FIFO holding captured bank reads with their row/tile tags.
// Push and pop may occur in the same cycle, including when full.
module stream_skid_fifo
    import bank_pkg::*;
#(
    parameter type T = elem_tag_t
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  T                                   wdata,
    input  logic                               pop,
    output T                                   rdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    T                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/bank_stream_ctrl.sv
// Read sequencer for one scratchpad bank port: walks a 2-D tile and streams it row-major.
// Defining BANK_STREAM_PERF_EN adds stall_cnt, a saturating count of backpressured busy cycles.
module bank_stream_ctrl
    import bank_pkg::*;
#(
    parameter int A_WID   = 10,
    parameter int D_WID   = 8,
    parameter int DIM_WID = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WID-1:0]   base_addr,
    input  logic [DIM_WID-1:0] n_rows,
    input  logic [DIM_WID-1:0] n_cols,
    input  logic [A_WID-1:0]   row_stride,
    output logic               busy,
    output logic               done,
`ifdef BANK_STREAM_PERF_EN
    output logic [15:0]        stall_cnt,
`endif
    bank_stream_ctrl_if.master bus
);

    typedef struct packed {
        logic [D_WID-1:0] data;
        logic             eol;
        logic             last;
    } tag_t;

    state_t             state_q;
    state_t             state_d;
    logic [A_WID-1:0]   stride_q;
    logic [A_WID-1:0]   row_base_q;
    logic [A_WID-1:0]   addr_q;
    logic [DIM_WID-1:0] rows_q;
    logic [DIM_WID-1:0] cols_q;
    logic [DIM_WID-1:0] row_q;
    logic [DIM_WID-1:0] col_q;
    logic               inflight_q;
    logic               inflight_eol_q;
    logic               inflight_last_q;
    logic               accept;
    logic               zero_dim;
    logic               issue;
    logic               issue_eol;
    logic               issue_last;
    logic               room;
    logic               pop;
    logic               fifo_valid;
    logic [1:0]         fifo_count;
    logic [2:0]         occupancy;
    tag_t               push_tag;
    tag_t               head_tag;

    assign accept     = (state_q == IDLE) && start;
    assign zero_dim   = (n_rows == '0) || (n_cols == '0);
    assign issue_eol  = (col_q == cols_q - DIM_WID'(1));
    assign issue_last = issue_eol && (row_q == rows_q - DIM_WID'(1));
    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid && bus.out_ready;

    // A new read may only go out if its data is guaranteed a FIFO slot one cycle later.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign room       = (occupancy < 3'(FIFO_DEPTH));
    assign issue      = (state_q == RUN) && room;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = zero_dim ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue && issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && head_tag.last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses advance incrementally: +1 along a row, +row_stride from the row start at eol.
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q        <= '0;
            row_base_q      <= '0;
            addr_q          <= '0;
            rows_q          <= '0;
            cols_q          <= '0;
            row_q           <= '0;
            col_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_eol_q  <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (accept) begin
                stride_q   <= row_stride;
                rows_q     <= n_rows;
                cols_q     <= n_cols;
                row_base_q <= base_addr;
                addr_q     <= base_addr;
                row_q      <= '0;
                col_q      <= '0;
            end else if (issue) begin
                if (issue_eol) begin
                    col_q      <= '0;
                    row_q      <= row_q + DIM_WID'(1);
                    row_base_q <= row_base_q + stride_q;
                    addr_q     <= row_base_q + stride_q;
                end else begin
                    col_q  <= col_q + DIM_WID'(1);
                    addr_q <= addr_q + A_WID'(1);
                end
            end
            inflight_q      <= issue;
            inflight_eol_q  <= issue && issue_eol;
            inflight_last_q <= issue && issue_last;
        end
    end

    assign push_tag = '{data: bus.mem_rdata, eol: inflight_eol_q, last: inflight_last_q};

    stream_skid_fifo #(
        .T (tag_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .wdata (push_tag),
        .pop   (pop),
        .rdata (head_tag),
        .count (fifo_count)
    );

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = issue ? addr_q : '0;
    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_valid ? head_tag.data : '0;
    assign bus.out_eol   = fifo_valid && head_tag.eol;
    assign bus.out_last  = fifo_valid && head_tag.last;

`ifdef BANK_STREAM_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_q <= '0;
        end else if (busy && fifo_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
